// File: rtl/sdram_sim_mp.sv
// rtl/sdram_sim_mp.sv - multi-port round-robin memory model with fixed access latency
// Optional refresh back-pressure is built when SDRAM_SIM_REFRESH_EN is defined.
module sdram_sim_mp #(
  parameter int    NPORT          = 4,
  parameter int    DW             = 16,
  parameter int    AW             = 22,
  parameter int    LAT            = 3,
  parameter int    REFRESH_PERIOD = 780,
  parameter int    REFRESH_LEN    = 8,
  parameter string INIT_FILE      = ""
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NPORT-1:0]        req_i,
  input  logic [NPORT-1:0]        we_i,
  input  logic [NPORT*AW-1:0]     addr_i,
  input  logic [NPORT*DW-1:0]     din_i,
  input  logic [NPORT*DW/8-1:0]   be_i,
  output logic [NPORT-1:0]        ack_o,
  output logic [NPORT*DW-1:0]     dout_o,
  output logic                    busy_o
);

  localparam int NB = DW / 8;
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CW = 16;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_REFRESH = 2'd2;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic [NPORT-1:0][AW-1:0] addr_v;
  logic [NPORT-1:0][DW-1:0] din_v;
  logic [NPORT-1:0][NB-1:0] be_v;

  logic [1:0]               state_q, state_d;
  logic [PW-1:0]            ptr_q, ptr_d, gnt_q, gnt_d;
  logic                     we_q, we_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic [DW-1:0]            din_q, din_d;
  logic [NB-1:0]            be_q, be_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NPORT-1:0]         ack_q, ack_d;
  logic [NPORT-1:0][DW-1:0] dout_q;
  logic                     pend_q;

  logic                     found;
  logic [PW-1:0]            sel, idx;
  logic [PW:0]              sum;
  logic                     do_access;

  assign addr_v = addr_i;
  assign din_v  = din_i;
  assign be_v   = be_i;

  // A port whose ack is on the wire this cycle still holds req; it must not be re-granted.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NPORT; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NPORT)) sum = sum - (PW+1)'(NPORT);
      idx = sum[PW-1:0];
      if (!found && req_i[idx] && !ack_q[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    din_d     = din_q;
    be_d      = be_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    do_access = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_REFRESH;
          cnt_d   = CW'(REFRESH_LEN - 1);
        end else if (found) begin
          state_d = S_ACCESS;
          gnt_d   = sel;
          we_d    = we_i[sel];
          addr_d  = addr_v[sel];
          din_d   = din_v[sel];
          be_d    = be_v[sel];
          cnt_d   = CW'(LAT - 1);
          ptr_d   = (sel == PW'(NPORT - 1)) ? '0 : sel + 1'b1;
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          do_access     = 1'b1;
          ack_d[gnt_q]  = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_REFRESH: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      if (do_access && !we_q) dout_q[gnt_q] <= mem[addr_q];
    end
  end

  // The array has no reset; a reset on the completing edge suppresses the write.
  always_ff @(posedge clk_i) begin
    if (!reset_i && do_access && we_q) begin
      for (int k = 0; k < NB; k++) begin
        if (be_q[k]) mem[addr_q][8*k +: 8] <= din_q[8*k +: 8];
      end
    end
  end

`ifdef SDRAM_SIM_REFRESH_EN
  logic [31:0] ref_cnt_q;

  // A new period wins over the clear so a refresh due on the entry edge is not lost.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ref_cnt_q <= '0;
      pend_q    <= 1'b0;
    end else if (ref_cnt_q == 32'(REFRESH_PERIOD - 1)) begin
      ref_cnt_q <= '0;
      pend_q    <= 1'b1;
    end else begin
      ref_cnt_q <= ref_cnt_q + 32'd1;
      if (state_q == S_IDLE) pend_q <= 1'b0;
    end
  end
`else
  assign pend_q = 1'b0;
`endif

  assign ack_o  = ack_q;
  assign dout_o = dout_q;
  assign busy_o = (state_q != S_IDLE);

endmodule
